mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
// - MEM stage of the LC-3b pipeline; consumes the EX/MEM latch outputs (ctrl op, ALU address, store data).
// - Sequences data-memory accesses: LDR/STR, LDB/STB, LDI/STI (two accesses). Stalls the pipe until done.
// - Registered load result feeds the MEM/WB latch.
// PARAMETERS
// - ADDR_W  16  data-memory address width
// - DATA_W  16  data word width (fixed at 16 for LC-3b; byte lanes = DATA_W/8 = 2)
// PORTS
// - clk            in   1   pipeline clock
// - reset          in   1   synchronous, active-high reset
// - req_valid      in   1   EX/MEM holds a live instruction (not a flush bubble)
// - mem_op         in   3   0 NONE,1 LDR,2 STR,3 LDB,4 STB,5 LDI,6 STI; 7 treated as NONE
// - addr_in        in   16  effective address (EX ALU result)
// - store_data     in   16  source register data for stores
// - advance        in   1   pipeline advancing this cycle (from hazard/stall control)
// - dmem_resp      in   1   data memory completed current access (1-cycle pulse)
// - dmem_rdata     in   16  data memory read data, valid with dmem_resp
// - dmem_read      out  1   read request, held until dmem_resp
// - dmem_write     out  1   write request, held until dmem_resp
// - dmem_address   out  16  access address
// - dmem_wdata     out  16  write data
// - dmem_byte_en   out  2   lane enables {hi,lo}
// - load_data      out  16  load result (zero-extended for LDB)
// - mem_stall      out  1   stage busy; pipeline must not advance
// - align_fault    out  1   misaligned word access flagged (MEM_ALIGN_TRAP_EN only; else tied 0)
// BEHAVIOUR
// - States: IDLE, ACC1, ACC2, DONE. All request outputs registered.
// - Reset: state IDLE; dmem_read/write 0, dmem_address/wdata 0, byte_en 00, load_data 0, align_fault 0.
// - Reset mid-access: next cycle request lines low, state IDLE; no resp is consumed after reset.
// - IDLE: if req_valid && op!=NONE -> ACC1 next cycle, request driven from that cycle. Else stay.
// - mem_stall (comb) = (IDLE && req_valid && op!=NONE) || ACC1 || ACC2. Low in DONE and idle.
// - ACC1: LDR/LDB/LDI read; STR/STB write; STI reads pointer. Hold all request signals until dmem_resp.
//   - resp, op LDR/LDB/STR/STB -> DONE; LDI/STI -> latch dmem_rdata as pointer -> ACC2.
// - ACC2: address = pointer with bit0 cleared; LDI read, STI write of store_data (byte_en 11); resp -> DONE.
// - DONE: load_data stable; stay until advance=1, then IDLE (prevents re-issuing the held instruction).
// - advance=1 in same cycle as entering DONE is legal: next cycle still DONE, exits on following advance.
// - Word ops (LDR/STR/LDI/STI first access): address bit0 cleared, byte_en 11.
// - LDB: read word at addr&~1, byte_en 11; load_data = {8'h00, addr[0] ? rdata[15:8] : rdata[7:0]}.
// - STB: wdata = {store_data[7:0], store_data[7:0]}; byte_en = addr[0] ? 10 : 01.
// - Stores leave load_data unchanged. load_data captured only on final resp of a load.
// - dmem_resp while not in ACC1/ACC2 ignored. Never read and write high together.
// - Latency: single access = 1 + memory wait + 1 (DONE) cycles; indirect adds one more access.
// CONFIGURATION
// - MEM_ALIGN_TRAP_EN defined: word op with addr_in[0]=1 (or odd LDI/STI pointer) issues no access;
//   align_fault=1 in DONE, load_data unchanged, cleared on leaving DONE.
// - MEM_ALIGN_TRAP_EN undefined: bit0 silently cleared, access proceeds; align_fault constant 0.
// TESTING
// - LDR addr 0x3002, resp after 2 waits with 0xBEEF -> dmem_read held 3 cycles, load_data 0xBEEF, stall low in DONE.
// - LDB addr 0x3005, rdata 0xA17F -> byte_en 11, address 0x3004, load_data 0x00A1.
// - STB addr 0x3004, store_data 0x12C3 -> wdata 0xC3C3, byte_en 01, dmem_write until resp, no load_data change.
// - STI addr 0x4000, pointer rdata 0x5001, data 0x7777 -> ACC1 read 0x4000, ACC2 write 0x5000 wdata 0x7777 be 11.
// - advance held 0 in DONE for 5 cycles -> exactly one memory access, no second request; IDLE after advance.
// - reset asserted during ACC2 of LDI -> read/write low next cycle, all outputs 0, stall low; LDR 0x0010 then works.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
// Latency: n/a (signal bundle only).
// Backpressure: master holds read/write, address, wdata and byte_en until the slave pulses dmem_resp.
// Signals:
//   dmem_read / dmem_write   request strobes, never both high
//   dmem_address             word-aligned access address
//   dmem_wdata / dmem_byte_en  store data and lane enables {hi,lo}
//   dmem_resp / dmem_rdata   1-cycle completion pulse and read data valid with it
interface mem_stage_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic                  dmem_read;
    logic                  dmem_write;
    logic [ADDR_W-1:0]     dmem_address;
    logic [DATA_W-1:0]     dmem_wdata;
    logic [DATA_W/8-1:0]   dmem_byte_en;
    logic                  dmem_resp;
    logic [DATA_W-1:0]     dmem_rdata;

    modport master (
        output dmem_read,
        output dmem_write,
        output dmem_address,
        output dmem_wdata,
        output dmem_byte_en,
        input  dmem_resp,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_read,
        input  dmem_write,
        input  dmem_address,
        input  dmem_wdata,
        input  dmem_byte_en,
        output dmem_resp,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// LC-3b MEM stage: sequences LDR/STR/LDB/STB/LDI/STI data accesses and holds the load result for MEM/WB.
// Latency: 1 issue cycle + memory wait per access (LDI/STI make two accesses) + 1 DONE cycle.
// Backpressure: mem_stall holds the pipe while an access is pending; DONE waits for advance before re-arming.
// Ports:
//   clk, reset                       clock and synchronous active-high reset
//   req_valid, mem_op, addr_in,      EX/MEM latch contents (op 0/7 = no access)
//   store_data, advance              pipeline advance from hazard control
//   dmem (mem_stage_if.master)       data-memory request/response bus
//   load_data, mem_stall, align_fault  load result, stage busy, misaligned word access flag
// Optional feature: define MEM_ALIGN_TRAP_EN to trap odd word addresses (and odd LDI/STI pointers)
// instead of silently clearing bit 0; without it align_fault stays 0.
module mem_stage #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [2:0]        mem_op,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] store_data,
    input  logic              advance,
    mem_stage_if.master       dmem,
    output logic [DATA_W-1:0] load_data,
    output logic              mem_stall,
    output logic              align_fault
);

    localparam int BE_W = DATA_W / 8;

    localparam logic [2:0] OP_LDR = 3'd1;
    localparam logic [2:0] OP_STR = 3'd2;
    localparam logic [2:0] OP_LDB = 3'd3;
    localparam logic [2:0] OP_STB = 3'd4;
    localparam logic [2:0] OP_LDI = 3'd5;
    localparam logic [2:0] OP_STI = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC1 = 2'd1,
        S_ACC2 = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [DATA_W-1:0]   sdata_q, sdata_d;
    logic                bsel_q, bsel_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   ld_q, ld_d;
    logic                fault_q, fault_d;

    logic                op_live;
    logic [ADDR_W-1:0]   word_addr;
    logic [ADDR_W-1:0]   ptr_addr;
    logic                trap_req;
    logic                trap_ptr;

    // Ops 0 and 7 are bubbles: nothing to access.
    assign op_live   = req_valid && (mem_op != 3'd0) && (mem_op != 3'd7);
    assign word_addr = {addr_in[ADDR_W-1:1], 1'b0};
    // Indirect pointer comes back on the data bus; its bit 0 is dropped for the second access.
    assign ptr_addr  = {dmem.dmem_rdata[ADDR_W-1:1], 1'b0};

`ifdef MEM_ALIGN_TRAP_EN
    logic is_word_op;
    assign is_word_op = (mem_op == OP_LDR) || (mem_op == OP_STR) ||
                        (mem_op == OP_LDI) || (mem_op == OP_STI);
    assign trap_req   = is_word_op && addr_in[0];
    assign trap_ptr   = dmem.dmem_rdata[0];
`else
    assign trap_req   = 1'b0;
    assign trap_ptr   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sdata_d = sdata_q;
        bsel_d  = bsel_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        ld_d    = ld_q;
        fault_d = fault_q;

        case (state_q)
            S_IDLE: begin
                if (op_live) begin
                    // Capture the instruction so the second access of LDI/STI
                    // does not depend on the EX/MEM latch staying put.
                    op_d    = mem_op;
                    sdata_d = store_data;
                    bsel_d  = addr_in[0];
                    if (trap_req) begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACC1;
                        addr_d  = word_addr;
                        be_d    = '1;
                        wdata_d = store_data;
                        rd_d    = (mem_op == OP_LDR) || (mem_op == OP_LDB) ||
                                  (mem_op == OP_LDI) || (mem_op == OP_STI);
                        wr_d    = (mem_op == OP_STR) || (mem_op == OP_STB);
                        if (mem_op == OP_STB) begin
                            // Byte replicated on both lanes; the enable picks the lane.
                            wdata_d = {store_data[7:0], store_data[7:0]};
                            be_d    = addr_in[0] ? 2'b10 : 2'b01;
                        end
                    end
                end
            end

            S_ACC1: begin
                if (dmem.dmem_resp) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = S_DONE;
                    case (op_q)
                        OP_LDR: ld_d = dmem.dmem_rdata;
                        OP_LDB: ld_d = {8'h00, bsel_q ? dmem.dmem_rdata[15:8]
                                                      : dmem.dmem_rdata[7:0]};
                        OP_LDI, OP_STI: begin
                            if (trap_ptr) begin
                                fault_d = 1'b1;
                            end else begin
                                state_d = S_ACC2;
                                addr_d  = ptr_addr;
                                be_d    = '1;
                                wdata_d = sdata_q;
                                rd_d    = (op_q == OP_LDI);
                                wr_d    = (op_q == OP_STI);
                            end
                        end
                        default: ;
                    endcase
                end
            end

            S_ACC2: begin
                if (dmem.dmem_resp) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = S_DONE;
                    if (op_q == OP_LDI) begin
                        ld_d = dmem.dmem_rdata;
                    end
                end
            end

            S_DONE: begin
                // Only leave once the pipe has moved the held instruction on,
                // otherwise IDLE would re-issue it.
                if (advance) begin
                    state_d = S_IDLE;
                    fault_d = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            sdata_q <= '0;
            bsel_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            ld_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sdata_q <= sdata_d;
            bsel_q  <= bsel_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ld_q    <= ld_d;
            fault_q <= fault_d;
        end
    end

    assign dmem.dmem_read    = rd_q;
    assign dmem.dmem_write   = wr_q;
    assign dmem.dmem_address = addr_q;
    assign dmem.dmem_wdata   = wdata_q;
    assign dmem.dmem_byte_en = be_q;
    assign load_data         = ld_q;
    assign align_fault       = fault_q;

    assign mem_stall = ((state_q == S_IDLE) && op_live) ||
                       (state_q == S_ACC1) || (state_q == S_ACC2);

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid;
    logic [2:0]  mem_op;
    logic [15:0] addr_in;
    logic [15:0] store_data;
    logic        advance;
    logic [15:0] load_data;
    logic        mem_stall;
    logic        align_fault;

    mem_stage_if #(.ADDR_W(16), .DATA_W(16)) dmem ();

    mem_stage #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .mem_op      (mem_op),
        .addr_in     (addr_in),
        .store_data  (store_data),
        .advance     (advance),
        .dmem        (dmem.master),
        .load_data   (load_data),
        .mem_stall   (mem_stall),
        .align_fault (align_fault)
    );

    typedef struct {
        logic        is_wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic        last;
    } acc_t;

    acc_t        exp_acc[$];
    logic [15:0] exp_ld[$];
    int          hold_q[$];
    logic [15:0] phys_mem [4096];
    logic [15:0] ref_mem  [4096];
    logic [15:0] ref_ld;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          done_count = 0;
    int          acc_start  = 0;
    int          force_wait = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    function automatic int idx(input logic [15:0] a);
        return int'(a[12:1]);
    endfunction

    function automatic acc_t mk(input logic w, input logic [15:0] a, input logic [15:0] d,
                                input logic [1:0] be, input logic last);
        acc_t e;
        e.is_wr = w; e.addr = a; e.wdata = d; e.be = be; e.last = last;
        return e;
    endfunction

    task automatic set_word(input logic [15:0] a, input logic [15:0] v);
        phys_mem[idx(a)] = v;
        ref_mem[idx(a)]  = v;
    endtask

    // Reference model: expected bus accesses and final load_data per instruction.
    task automatic model_issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] sd);
        logic [15:0] wa, ptr;
        wa = {a[15:1], 1'b0};
        case (op)
            3'd1: begin
                exp_acc.push_back(mk(1'b0, wa, 16'h0, 2'b11, 1'b1));
                ref_ld = ref_mem[idx(wa)];
                exp_ld.push_back(ref_ld);
            end
            3'd2: begin
                exp_acc.push_back(mk(1'b1, wa, sd, 2'b11, 1'b1));
                ref_mem[idx(wa)] = sd;
                exp_ld.push_back(ref_ld);
            end
            3'd3: begin
                exp_acc.push_back(mk(1'b0, wa, 16'h0, 2'b11, 1'b1));
                ref_ld = a[0] ? {8'h00, ref_mem[idx(wa)][15:8]} : {8'h00, ref_mem[idx(wa)][7:0]};
                exp_ld.push_back(ref_ld);
            end
            3'd4: begin
                exp_acc.push_back(mk(1'b1, wa, {sd[7:0], sd[7:0]}, a[0] ? 2'b10 : 2'b01, 1'b1));
                if (a[0]) ref_mem[idx(wa)][15:8] = sd[7:0];
                else      ref_mem[idx(wa)][7:0]  = sd[7:0];
                exp_ld.push_back(ref_ld);
            end
            3'd5: begin
                ptr = ref_mem[idx(wa)] & 16'hFFFE;
                exp_acc.push_back(mk(1'b0, wa, 16'h0, 2'b11, 1'b0));
                exp_acc.push_back(mk(1'b0, ptr, 16'h0, 2'b11, 1'b1));
                ref_ld = ref_mem[idx(ptr)];
                exp_ld.push_back(ref_ld);
            end
            3'd6: begin
                ptr = ref_mem[idx(wa)] & 16'hFFFE;
                exp_acc.push_back(mk(1'b0, wa, 16'h0, 2'b11, 1'b0));
                exp_acc.push_back(mk(1'b1, ptr, sd, 2'b11, 1'b1));
                ref_mem[idx(ptr)] = sd;
                exp_ld.push_back(ref_ld);
            end
            default: ;
        endcase
    endtask

    // Memory responder: random (or forced) wait, then a 1-cycle resp pulse.
    bit resp_busy = 0;
    int resp_cnt  = 0;
    always @(negedge clk) begin
        if (reset) begin
            dmem.dmem_resp = 1'b0;
            resp_busy = 0;
        end else begin
            if (dmem.dmem_resp) begin
                dmem.dmem_resp = 1'b0;
                resp_busy = 0;
            end
            if (!resp_busy && (dmem.dmem_read || dmem.dmem_write)) begin
                resp_busy = 1;
                resp_cnt  = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
                hold_q.push_back(resp_cnt + 1);
            end
            if (resp_busy && !dmem.dmem_resp) begin
                if (resp_cnt == 0) begin
                    if (dmem.dmem_write) begin
                        if (dmem.dmem_byte_en[1]) phys_mem[idx(dmem.dmem_address)][15:8] = dmem.dmem_wdata[15:8];
                        if (dmem.dmem_byte_en[0]) phys_mem[idx(dmem.dmem_address)][7:0]  = dmem.dmem_wdata[7:0];
                        dmem.dmem_rdata = 16'($urandom);
                    end else begin
                        dmem.dmem_rdata = phys_mem[idx(dmem.dmem_address)];
                    end
                    dmem.dmem_resp = 1'b1;
                end else begin
                    resp_cnt--;
                end
            end
        end
    end

    // Monitor: pops expected accesses on each new request, expected load on final resp.
    logic prev_req = 1'b0;
    acc_t cur = '{1'b0, 16'h0, 16'h0, 2'b00, 1'b0};
    int   held = 0;
    always @(posedge clk) begin
        #1;
        if (reset) begin
            exp_acc.delete();
            exp_ld.delete();
            hold_q.delete();
            prev_req = 1'b0;
            held = 0;
            cur.last = 1'b0;
        end else begin
            if (dmem.dmem_read && dmem.dmem_write) fail_now("read_and_write_together");
            if (dmem.dmem_resp) begin
                if (hold_q.size() > 0) check("req_hold_cycles", held, hold_q.pop_front());
                if (cur.last) begin
                    done_count++;
                    if (exp_ld.size() == 0) fail_now("unexpected_done");
                    else check("load_data", load_data, exp_ld.pop_front());
                    check("stall_in_done", mem_stall, 1'b0);
                    cur.last = 1'b0;
                end
            end
            if ((dmem.dmem_read || dmem.dmem_write) && (dmem.dmem_resp || !prev_req)) begin
                acc_start++;
                if (exp_acc.size() == 0) begin
                    $display("FAIL unexpected_request: addr %h rd %b wr %b", dmem.dmem_address,
                             dmem.dmem_read, dmem.dmem_write);
                    n_checks++;
                end else begin
                    cur = exp_acc.pop_front();
                    check("acc_is_write", dmem.dmem_write, cur.is_wr);
                    check("acc_is_read", dmem.dmem_read, !cur.is_wr);
                    check("acc_address", dmem.dmem_address, cur.addr);
                    check("acc_byte_en", dmem.dmem_byte_en, cur.be);
                    if (cur.is_wr) check("acc_wdata", dmem.dmem_wdata, cur.wdata);
                    check("stall_in_access", mem_stall, 1'b1);
                end
                held = 1;
            end else if (dmem.dmem_read || dmem.dmem_write) begin
                held++;
            end
            prev_req = dmem.dmem_read || dmem.dmem_write;
        end
    end

    // Issue one instruction, wait for DONE, then advance after `hold` cycles (-1 random).
    // adv_early keeps advance high from issue so it coincides with DONE entry.
    task automatic run_txn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] sd,
                           input bit adv_early, input int hold);
        int target, n;
        @(negedge clk);
        target = done_count + 1;
        model_issue(op, a, sd);
        req_valid  = 1'b1;
        mem_op     = op;
        addr_in    = a;
        store_data = sd;
        if (op == 3'd0 || op == 3'd7) begin
            advance = 1'b0;
            @(negedge clk);
            check("stall_bubble", mem_stall, 1'b0);
            @(negedge clk);
            req_valid = 1'b0;
            return;
        end
        advance = adv_early;
        for (int k = 0; k < 300 && done_count < target; k++) @(negedge clk);
        if (done_count < target) begin
            fail_now("timeout_waiting_done");
            req_valid = 1'b0;
            advance = 1'b0;
            return;
        end
        if (adv_early) begin
            check("stall_done_adv_early", mem_stall, 1'b0);
            @(negedge clk);
        end else begin
            n = (hold >= 0) ? hold : int'($urandom_range(0, 5));
            for (int k = 0; k < n; k++) begin
                @(negedge clk);
                check("stall_done_wait", mem_stall, 1'b0);
            end
            advance = 1'b1;
            @(negedge clk);
        end
        advance   = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [2:0]  op;
        logic [15:0] a;
        for (int i = 0; i < 4096; i++) begin
            phys_mem[i] = 16'($urandom);
            ref_mem[i]  = phys_mem[i];
        end
        dmem.dmem_resp  = 1'b0;
        dmem.dmem_rdata = 16'h0;
        reset = 1'b1; req_valid = 1'b0; mem_op = 3'd0; addr_in = 16'h0;
        store_data = 16'h0; advance = 1'b0; ref_ld = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_read", dmem.dmem_read, 1'b0);
        check("rst_write", dmem.dmem_write, 1'b0);
        check("rst_address", dmem.dmem_address, 16'h0);
        check("rst_wdata", dmem.dmem_wdata, 16'h0);
        check("rst_byte_en", dmem.dmem_byte_en, 2'b00);
        check("rst_load_data", load_data, 16'h0);
        check("rst_align_fault", align_fault, 1'b0);
        check("rst_stall", mem_stall, 1'b0);
        reset = 1'b0;

        // Directed cases
        set_word(16'h3002, 16'hBEEF);
        force_wait = 2;
        run_txn(3'd1, 16'h3002, 16'h0, 1'b0, 0);
        force_wait = -1;
        set_word(16'h3004, 16'hA17F);
        run_txn(3'd3, 16'h3005, 16'h0, 1'b0, -1);
        run_txn(3'd4, 16'h3004, 16'h12C3, 1'b0, -1);
        set_word(16'h4000, 16'h5001);
        run_txn(3'd6, 16'h4000, 16'h7777, 1'b0, -1);
        run_txn(3'd1, 16'h5000, 16'h0, 1'b0, 5);
        run_txn(3'd0, 16'h3000, 16'h1111, 1'b0, -1);
        run_txn(3'd7, 16'h3000, 16'h2222, 1'b0, -1);
        run_txn(3'd2, 16'h3011, 16'h5A5A, 1'b0, -1);
        run_txn(3'd1, 16'h3011, 16'h0, 1'b1, -1);

        // Reset during the second access of an LDI
        set_word(16'h3100, 16'h3201);
        set_word(16'h3200, 16'h1234);
        force_wait = 3;
        @(negedge clk);
        base = acc_start;
        model_issue(3'd5, 16'h3100, 16'h0);
        req_valid = 1'b1; mem_op = 3'd5; addr_in = 16'h3100; store_data = 16'h0;
        for (int k = 0; k < 100 && acc_start < base + 2; k++) @(negedge clk);
        if (acc_start < base + 2) fail_now("timeout_waiting_acc2");
        reset = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        check("midrst_read", dmem.dmem_read, 1'b0);
        check("midrst_write", dmem.dmem_write, 1'b0);
        check("midrst_address", dmem.dmem_address, 16'h0);
        check("midrst_byte_en", dmem.dmem_byte_en, 2'b00);
        check("midrst_load_data", load_data, 16'h0);
        check("midrst_stall", mem_stall, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        ref_ld = 16'h0;
        force_wait = -1;
        set_word(16'h0010, 16'hC0DE);
        run_txn(3'd1, 16'h0010, 16'h0, 1'b0, -1);

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            op = 3'($urandom_range(0, 7));
            a  = {7'b0011000, 9'($urandom)};
            run_txn(op, a, 16'($urandom), ($urandom_range(0, 3) == 0), -1);
        end

        repeat (4) @(negedge clk);
        check("exp_acc_drained", exp_acc.size(), 0);
        check("exp_ld_drained", exp_ld.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
